// File: rtl/wbu_pkg.sv
// Shared WBU codeword definitions: header constants, serializer state
// encoding and the header-to-sextet-count decode.
package wbu_pkg;

    localparam logic [5:0] CW_IDLE      = 6'h00;
    localparam logic [5:0] CW_BUSBUSY   = 6'h01;
    localparam logic [5:0] CW_INTERRUPT = 6'h04;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_NL   = 2'd2
    } state_t;

    // Sextet count from codeword bits [35:32]
    function automatic logic [2:0] wbu_cw_len(input logic [3:0] hdr);
        logic [2:0] len;
        casez (hdr)
            4'b000?: len = 3'd1;
            4'b001?: len = 3'd2;
            4'b010?: len = 3'd3;
            4'b011?: len = 3'd4;
            4'b10??: len = 3'd6;
            default: len = 3'd2;
        endcase
        return len;
    endfunction

    // Words that end a line: single-sextet control words and full 6-sextet words
    function automatic logic wbu_cw_nl(input logic [3:0] hdr);
        return (hdr[3:1] == 3'b000) || (hdr[3:2] == 2'b10);
    endfunction

endpackage

// File: rtl/wbu_cw_len_dec.sv
// Combinational codeword header decode to sextet count; also intended for
// reuse by the receive-side deword checker.
module wbu_cw_len_dec
    import wbu_pkg::*;
(
    input  logic [3:0] hdr,
    output logic [2:0] len
);

    assign len = wbu_cw_len(hdr);

endmodule

// File: rtl/wbu_deword.sv
// WBU return-path serializer: 36-bit codeword in, MSB-first 6-bit sextets out.
// Optional end-of-line beats are enabled by defining WBU_NEWLINE_EN.
module wbu_deword
    import wbu_pkg::*;
#(
    parameter logic [5:0] NL_SEXTET = 6'h00
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_stb,
    input  logic [35:0] i_codword,
    output logic        o_busy,
    output logic        o_stb,
    output logic [5:0]  o_sextet,
    output logic        o_nl,
    input  logic        i_tx_busy
);

    state_t      state;
    logic [35:0] sreg;
    logic [2:0]  remain;
    logic [2:0]  len;
    logic        nl_pend;
    logic        beat_done;
    logic        final_beat;
    logic        accept;

    wbu_cw_len_dec u_len_dec (
        .hdr (i_codword[35:32]),
        .len (len)
    );

    assign beat_done  = o_stb && !i_tx_busy;
    assign final_beat = (state == ST_NL) ||
                        ((state == ST_SEND) && (remain == 3'd0) && !nl_pend);
    // Dropping busy on the completing final beat lets the next word load with no bubble
    assign o_busy     = (state != ST_IDLE) && !(final_beat && beat_done);
    assign accept     = i_stb && !o_busy;
    assign o_sextet   = (state == ST_NL) ? NL_SEXTET : sreg[35:30];

`ifdef WBU_NEWLINE_EN
    logic nl_q;
    assign nl_pend = nl_q;
    assign o_nl    = (state == ST_NL);
`else
    assign nl_pend = 1'b0;
    assign o_nl    = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state  <= ST_IDLE;
            sreg   <= '0;
            remain <= '0;
            o_stb  <= 1'b0;
`ifdef WBU_NEWLINE_EN
            nl_q   <= 1'b0;
`endif
        end else if (accept) begin
            state  <= ST_SEND;
            sreg   <= i_codword;
            remain <= len - 3'd1;
            o_stb  <= 1'b1;
`ifdef WBU_NEWLINE_EN
            nl_q   <= wbu_cw_nl(i_codword[35:32]);
`endif
        end else if (beat_done) begin
            case (state)
                ST_SEND: begin
                    if (remain != 3'd0) begin
                        sreg   <= {sreg[29:0], 6'd0};
                        remain <= remain - 3'd1;
                    end else if (nl_pend) begin
                        state <= ST_NL;
                    end else begin
                        state <= ST_IDLE;
                        o_stb <= 1'b0;
                    end
                end
                ST_NL: begin
                    state <= ST_IDLE;
                    o_stb <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    o_stb <= 1'b0;
                end
            endcase
        end
    end

endmodule
